// File: rtl/redmule_tile_pkg.sv
// rtl/redmule_tile_pkg.sv - shared types for the tile core data port
// Purpose: request/response bundles of the core data port, the atomic
//          operation codes understood by the memory-side responder, and
//          the responder's FSM state type.
// Ports:   none (package).
package redmule_tile_pkg;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic [5:0]  atop;
      logic [3:0]  be;
      logic [1:0]  memtype;
      logic [2:0]  prot;
      logic        dbg;
      logic [31:0] wdata;
      logic        we;
   } core_data_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        err;
      logic        exokay;
   } core_data_rsp_t;

   // Atomic codes: bit 5 marks an atomic, bits 4:0 carry the RISC-V funct5.
   localparam logic [5:0] ATOP_NONE    = 6'h00;
   localparam logic [5:0] ATOP_AMOADD  = 6'h20;
   localparam logic [5:0] ATOP_AMOSWAP = 6'h21;
   localparam logic [5:0] ATOP_AMOXOR  = 6'h24;
   localparam logic [5:0] ATOP_AMOOR   = 6'h28;
   localparam logic [5:0] ATOP_AMOAND  = 6'h2C;

   typedef enum logic {
      IDLE,
      AMO_WB
   } obi_rsp_state_e;

   // True for the atomics this responder can execute as read-modify-write.
   function automatic logic atop_supported(input logic [5:0] atop);
      return (atop == ATOP_AMOADD) || (atop == ATOP_AMOSWAP) ||
             (atop == ATOP_AMOXOR) || (atop == ATOP_AMOOR)   ||
             (atop == ATOP_AMOAND);
   endfunction

endpackage

// File: rtl/core_data_amo_alu.sv
// rtl/core_data_amo_alu.sv - combinational ALU for atomic read-modify-write
// Purpose: computes the word written back by an atomic memory operation.
// Ports:   old_i     - word read from memory
//          operand_i - operand supplied with the request
//          atop_i    - atomic operation code
//          result_o  - word to write back
module core_data_amo_alu
   import redmule_tile_pkg::*;
(
   input  logic [31:0] old_i,
   input  logic [31:0] operand_i,
   input  logic [5:0]  atop_i,
   output logic [31:0] result_o
);

   always_comb begin
      result_o = old_i;
      case (atop_i)
         ATOP_AMOADD:  result_o = old_i + operand_i;  // wraps modulo 2^32
         ATOP_AMOSWAP: result_o = operand_i;
         ATOP_AMOXOR:  result_o = old_i ^ operand_i;
         ATOP_AMOOR:   result_o = old_i | operand_i;
         ATOP_AMOAND:  result_o = old_i & operand_i;
         default:      result_o = old_i;
      endcase
   end

endmodule

// File: rtl/core_data_obi_responder.sv
// rtl/core_data_obi_responder.sv - core data port responder in front of one SRAM bank
// Purpose: serves loads/stores at one per cycle into a 1-cycle-latency word
//          SRAM, executes atomics as read-then-write, and answers illegal
//          accesses with err.
// Ports:   clk_i, rst_i  - clock, asynchronous active-high reset
//          data_req_i    - core data request bundle
//          data_rsp_o    - core data response bundle
//          mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o - SRAM command
//          mem_rdata_i   - SRAM read data, valid the cycle after a read strobe
module core_data_obi_responder
   import redmule_tile_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned SIZE_BYTES = 65536,
   parameter int unsigned MEM_AW     = $clog2(SIZE_BYTES / 4)
)
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  core_data_req_t       data_req_i,
   output core_data_rsp_t       data_rsp_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [MEM_AW-1:0]    mem_addr_o,
   output logic [3:0]           mem_be_o,
   output logic [31:0]          mem_wdata_o,
   input  logic [31:0]          mem_rdata_i
);

   localparam logic [31:0] SIZE_W = 32'(SIZE_BYTES);

   obi_rsp_state_e     state_q, state_d;
   logic               rvalid_q, rvalid_d;
   logic               err_q, err_d;
   logic               rdsel_q, rdsel_d;     // response carries SRAM read data
   logic [31:0]        wdata_q, wdata_d;
   logic [5:0]         atop_q, atop_d;
   logic [MEM_AW-1:0]  addr_q, addr_d;

   logic [31:0]        offset;
   logic [MEM_AW-1:0]  word_addr;
   logic               in_range, is_amo, legal, gnt;
   logic [31:0]        amo_result;
   logic               unused_ok;

   assign offset    = data_req_i.addr - BASE_ADDR;
   assign word_addr = offset[MEM_AW+1:2];
   assign in_range  = (data_req_i.addr >= BASE_ADDR) && (offset < SIZE_W);
   assign is_amo    = (data_req_i.atop != ATOP_NONE);
   assign legal     = in_range &&
                      (!is_amo || (atop_supported(data_req_i.atop) &&
                                   (data_req_i.addr[1:0] == 2'b00)));
   // Gated by reset so that no grant is visible while reset is held.
   assign gnt       = data_req_i.req && (state_q == IDLE) && !rst_i;

   assign unused_ok = ^{data_req_i.memtype, data_req_i.prot, data_req_i.dbg, offset};

   core_data_amo_alu u_amo_alu (
      .old_i     (mem_rdata_i),
      .operand_i (wdata_q),
      .atop_i    (atop_q),
      .result_o  (amo_result)
   );

   // State register; reset drops a pending write-back together with its response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdsel_q  <= 1'b0;
         wdata_q  <= '0;
         atop_q   <= '0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdsel_q  <= rdsel_d;
         wdata_q  <= wdata_d;
         atop_q   <= atop_d;
         addr_q   <= addr_d;
      end
   end

   // Next state: every grant produces exactly one response the next cycle.
   always_comb begin
      state_d  = state_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      rdsel_d  = 1'b0;
      wdata_d  = wdata_q;
      atop_d   = atop_q;
      addr_d   = addr_q;
      case (state_q)
         IDLE: begin
            if (gnt) begin
               rvalid_d = 1'b1;
               err_d    = !legal;
               rdsel_d  = legal && (is_amo || !data_req_i.we);
               if (legal && is_amo) begin
                  state_d = AMO_WB;
                  wdata_d = data_req_i.wdata;
                  atop_d  = data_req_i.atop;
                  addr_d  = word_addr;
               end
            end
         end
         AMO_WB: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: SRAM command and response bundle.
   always_comb begin
      data_rsp_o        = '0;
      data_rsp_o.gnt    = gnt;
      data_rsp_o.rvalid = rvalid_q;
      data_rsp_o.err    = err_q;
      data_rsp_o.rdata  = rdsel_q ? mem_rdata_i : 32'h0;
      data_rsp_o.exokay = 1'b0;
      mem_req_o         = 1'b0;
      mem_we_o          = 1'b0;
      mem_addr_o        = '0;
      mem_be_o          = 4'h0;
      mem_wdata_o       = 32'h0;
      case (state_q)
         IDLE: begin
            if (gnt && legal) begin
               mem_req_o   = 1'b1;
               mem_addr_o  = word_addr;
               // Atomics first read the full word; be is ignored for them.
               mem_we_o    = is_amo ? 1'b0 : data_req_i.we;
               mem_be_o    = is_amo ? 4'hF : data_req_i.be;
               mem_wdata_o = is_amo ? 32'h0 : data_req_i.wdata;
            end
         end
         AMO_WB: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = addr_q;
            mem_be_o    = 4'hF;
            mem_wdata_o = amo_result;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_core_data_obi_responder.sv
// tb/tb_core_data_obi_responder.sv - scoreboard bench for core_data_obi_responder
module tb_core_data_obi_responder;
   import redmule_tile_pkg::*;

   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam int          SIZE = 65536;
   localparam int          AW   = 14;
   localparam int          NW   = SIZE / 4;

   logic            clk = 1'b0;
   logic            rst;
   core_data_req_t  req_s;
   core_data_rsp_t  rsp;
   logic            mem_req, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [3:0]      mem_be;
   logic [31:0]     mem_wdata;
   logic [31:0]     mem_rdata;

   logic [31:0]     mem  [0:NW-1];
   logic [31:0]     snap [0:NW-1];
   int              mem_req_cnt = 0;
   int              cyc = 0;
   int              checks = 0;
   int              errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          gcyc;
   } exp_t;
   exp_t sbq[$];

   core_data_obi_responder #(
      .BASE_ADDR  (BASE),
      .SIZE_BYTES (SIZE)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .data_req_i  (req_s),
      .data_rsp_o  (rsp),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_be_o    (mem_be),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: byte-enabled writes, read data one cycle after the strobe.
   always @(posedge clk) begin
      if (mem_req) begin
         mem_req_cnt <= mem_req_cnt + 1;
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= mem[mem_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && rsp.rvalid) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid actual=1 required=0");
         end else begin
            e = sbq.pop_front();
            chk("rsp_rdata", rsp.rdata, e.rdata);
            chk("rsp_err", 32'(rsp.err), 32'(e.err));
            chk("rsp_exokay", 32'(rsp.exokay), 32'h0);
            chk("rsp_cycle", cyc, e.gcyc + 1);
         end
      end
   end

   // Drive one request, wait for its grant, push the expected response.
   task automatic do_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input logic [5:0] at,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input bit push, output int gc);
      req_s.req   = 1'b1;
      req_s.addr  = a;
      req_s.we    = we;
      req_s.be    = be;
      req_s.wdata = wd;
      req_s.atop  = at;
      gc = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rsp.gnt) begin
            gc = cyc;
            break;
         end
      end
      if (gc < 0) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout actual=none required=gnt addr=%h", a);
      end else if (push) begin
         sbq.push_back('{exp_rd, exp_err, gc});
      end
      @(posedge clk);
      #1;
      req_s.req = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_gnt"}, 32'(rsp.gnt), 32'h0);
      chk({tag, "_rvalid"}, 32'(rsp.rvalid), 32'h0);
      chk({tag, "_err"}, 32'(rsp.err), 32'h0);
      chk({tag, "_exokay"}, 32'(rsp.exokay), 32'h0);
      chk({tag, "_rdata"}, rsp.rdata, 32'h0);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int g1, g2, cnt0, diffs;
      rst   = 1'b1;
      req_s = '0;
      for (int i = 0; i < NW; i++) mem[i] = 32'h0;
      mem[8]    = 32'hFFFF_FFFF;   // BASE+0x20
      mem[12]   = 32'h0000_000F;   // BASE+0x30
      mem[13]   = 32'hA5A5_A5A5;   // BASE+0x34
      mem[20]   = 32'h0000_0010;   // BASE+0x50
      mem[NW-1] = 32'hCAFE_F00D;   // last word

      // Reset: outputs quiet even with a legal request pending.
      repeat (2) @(posedge clk);
      #1;
      req_s.req  = 1'b1;
      req_s.addr = BASE + 32'h10;
      #1;
      chk_outputs_zero("reset");
      @(posedge clk);
      #1;
      req_s.req = 1'b0;
      rst = 1'b0;

      // Write then read back-to-back.
      do_req(BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, ATOP_NONE, 32'h0, 1'b0, 1, g1);
      do_req(BASE + 32'h10, 1'b0, 4'hF, 32'h0, ATOP_NONE, 32'hDEAD_BEEF, 1'b0, 1, g2);
      chk("b2b_grant_gap", g2 - g1, 1);

      // Partial byte write to byte 1.
      do_req(BASE + 32'h10, 1'b1, 4'b0010, 32'h0000_AA00, ATOP_NONE, 32'h0, 1'b0, 1, g1);
      do_req(BASE + 32'h10, 1'b0, 4'hF, 32'h0, ATOP_NONE, 32'hDEAD_AAEF, 1'b0, 1, g1);

      // be==0 write still strobes the SRAM but changes nothing.
      cnt0 = mem_req_cnt;
      do_req(BASE + 32'h10, 1'b1, 4'h0, 32'h1234_5678, ATOP_NONE, 32'h0, 1'b0, 1, g1);
      do_req(BASE + 32'h10, 1'b0, 4'hF, 32'h0, ATOP_NONE, 32'hDEAD_AAEF, 1'b0, 1, g1);
      chk("be0_strobes", mem_req_cnt - cnt0, 2);

      // AMOADD wraps; grant blocked for one cycle.
      do_req(BASE + 32'h20, 1'b0, 4'hF, 32'h2, ATOP_AMOADD, 32'hFFFF_FFFF, 1'b0, 1, g1);
      req_s.req  = 1'b1;
      req_s.addr = BASE + 32'h20;
      req_s.we   = 1'b0;
      req_s.atop = ATOP_NONE;
      #1;
      chk("gnt_low_in_amo_wb", 32'(rsp.gnt), 32'h0);
      do_req(BASE + 32'h20, 1'b0, 4'hF, 32'h0, ATOP_NONE, 32'h0000_0001, 1'b0, 1, g2);
      chk("amo_grant_gap", g2 - g1, 2);
      chk("amoadd_mem", mem[8], 32'h0000_0001);

      // Illegal accesses: err, no SRAM access, memory untouched.
      @(posedge clk);
      #1;
      for (int i = 0; i < NW; i++) snap[i] = mem[i];
      cnt0 = mem_req_cnt;
      do_req(BASE + SIZE, 1'b0, 4'hF, 32'h0, ATOP_NONE, 32'h0, 1'b1, 1, g1);
      do_req(BASE + 32'h2, 1'b0, 4'hF, 32'h5, ATOP_AMOSWAP, 32'h0, 1'b1, 1, g1);
      do_req(BASE + 32'h30, 1'b0, 4'hF, 32'h5, 6'h22, 32'h0, 1'b1, 1, g1);
      do_req(BASE - 32'h4, 1'b1, 4'hF, 32'h5, ATOP_NONE, 32'h0, 1'b1, 1, g1);
      do_req(BASE + 32'h30, 1'b0, 4'hF, 32'h5, 6'h30, 32'h0, 1'b1, 1, g1);
      @(posedge clk);
      #1;
      chk("illegal_no_strobe", mem_req_cnt - cnt0, 0);
      diffs = 0;
      for (int i = 0; i < NW; i++) if (mem[i] !== snap[i]) diffs++;
      chk("illegal_mem_untouched", diffs, 0);

      // AMOOR (be ignored) then AMOAND back-to-back.
      do_req(BASE + 32'h30, 1'b0, 4'h0, 32'h0F0, ATOP_AMOOR, 32'h00F, 1'b0, 1, g1);
      do_req(BASE + 32'h30, 1'b0, 4'hF, 32'h0F0, ATOP_AMOAND, 32'h0FF, 1'b0, 1, g1);
      do_req(BASE + 32'h30, 1'b0, 4'hF, 32'h0, ATOP_NONE, 32'h0F0, 1'b0, 1, g1);

      // AMOXOR and AMOSWAP.
      do_req(BASE + 32'h34, 1'b0, 4'hF, 32'hFFFF_0000, ATOP_AMOXOR, 32'hA5A5_A5A5, 1'b0, 1, g1);
      do_req(BASE + 32'h34, 1'b0, 4'hF, 32'h1122_3344, ATOP_AMOSWAP, 32'h5A5A_A5A5, 1'b0, 1, g1);
      do_req(BASE + 32'h34, 1'b0, 4'hF, 32'h0, ATOP_NONE, 32'h1122_3344, 1'b0, 1, g1);

      // Last word of the bank.
      do_req(BASE + SIZE - 4, 1'b0, 4'hF, 32'h0, ATOP_NONE, 32'hCAFE_F00D, 1'b0, 1, g1);

      // Reset in the write-back cycle of an AMO.
      cnt0 = mem_req_cnt;
      do_req(BASE + 32'h50, 1'b0, 4'hF, 32'h5, ATOP_AMOADD, 32'h0, 1'b0, 0, g1);
      rst        = 1'b1;
      req_s.req  = 1'b1;
      req_s.addr = BASE + 32'h50;
      req_s.atop = ATOP_NONE;
      #1;
      chk_outputs_zero("mid_amo_reset");
      repeat (2) @(posedge clk);
      #1;
      chk("mid_amo_reset_mem", mem[20], 32'h0000_0010);
      chk("mid_amo_reset_strobes", mem_req_cnt - cnt0, 1);
      req_s.req = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      do_req(BASE + 32'h50, 1'b0, 4'hF, 32'h0, ATOP_NONE, 32'h0000_0010, 1'b0, 1, g1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
